// File: rtl/ro_readout_pkg.sv
// Shared types and constants for the region readout scanner.
// Holds the FSM state encoding, default widths and the layout of the
// 34-bit word streamed to the SoC-side collector.
package ro_readout_pkg;

  localparam int RO_ADDR_W    = 5;
  localparam int RO_DATA_W    = 24;

  // Output word layout: {region[4:0], addr[4:0], data[23:0]}
  localparam int DATA_LSB     = 0;
  localparam int ADDR_LSB     = 24;
  localparam int REGION_LSB   = 29;
  localparam int WORD_W       = 34;
  localparam int FIELD_W      = 5;
  localparam int DATA_FIELD_W = ADDR_LSB - DATA_LSB;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    WAIT,
    CAPTURE,
    EMIT,
    DONE
  } state_t;

  // Assemble one output word; narrower fields are zero-extended by the caller.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [FIELD_W-1:0]      region,
    input logic [FIELD_W-1:0]      addr,
    input logic [DATA_FIELD_W-1:0] data
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[REGION_LSB +: FIELD_W]    = region;
    w[ADDR_LSB +: FIELD_W]      = addr;
    w[DATA_LSB +: DATA_FIELD_W] = data;
    return w;
  endfunction

endpackage

// File: rtl/ro_snapshot_mux.sv
// Snapshot storage for one address worth of region data.
// All regions are captured on the same clock edge so the readout is a
// coherent picture, then read back one region at a time by index.
module ro_snapshot_mux
  import ro_readout_pkg::*;
#(
  parameter int NUM_REGION = 17,
  parameter int DATA_W     = RO_DATA_W
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         capture_i,
  input  logic [NUM_REGION*DATA_W-1:0] data_i,
  input  logic [FIELD_W-1:0]           rd_idx_i,
  output logic [DATA_W-1:0]            rd_data_o
);

  logic [DATA_W-1:0] snap_q [NUM_REGION];

  // Latch every region slice together when the strobe fires
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < NUM_REGION; r++) snap_q[r] <= '0;
    end else if (capture_i) begin
      for (int r = 0; r < NUM_REGION; r++) snap_q[r] <= data_i[r*DATA_W +: DATA_W];
    end
  end

  // Read port; indices past the last region return zero
  always_comb begin
    rd_data_o = '0;
    for (int r = 0; r < NUM_REGION; r++) begin
      if (rd_idx_i == FIELD_W'(r)) rd_data_o = snap_q[r];
    end
  end

endmodule

// File: rtl/ro_readout_scanner.sv
// Initiator side of the region readout interface.
// Broadcasts one address, waits for the regions to settle, snapshots all
// region data at once and streams it out word by word over valid/ready.
module ro_readout_scanner
  import ro_readout_pkg::*;
#(
  parameter int NUM_REGION = 17,
  parameter int ADDR_W     = RO_ADDR_W,
  parameter int DATA_W     = RO_DATA_W,
  parameter int NUM_ADDR   = 10,
  parameter int SETTLE     = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start_i,
  input  logic                         cont_i,
  output logic [ADDR_W-1:0]            addr_o,
  input  logic [NUM_REGION*DATA_W-1:0] data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WORD_W-1:0]            out_data_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [FIELD_W-1:0]  LAST_REGION = FIELD_W'(NUM_REGION - 1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR   = ADDR_W'(NUM_ADDR - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [FIELD_W-1:0]  region_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [WORD_W-1:0]   word_q;

  logic                capture;
  logic                handshake;
  logic                region_last;
  logic                addr_last;
  logic [FIELD_W-1:0]  rd_idx;
  logic [DATA_W-1:0]   rd_data;

  assign handshake   = out_valid_o && out_ready_i;
  assign region_last = (region_q == LAST_REGION);
  assign addr_last   = (addr_q == LAST_ADDR);
  assign rd_idx      = region_q + FIELD_W'(1);
  assign addr_o      = addr_q;
  assign out_data_o  = word_q;

  ro_snapshot_mux #(
    .NUM_REGION (NUM_REGION),
    .DATA_W     (DATA_W)
  ) u_snapshot (
    .clk       (clk),
    .rstn      (rstn),
    .capture_i (capture),
    .data_i    (data_i),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decision; EMIT only leaves on the handshake of the last region
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SET;
      SET:     state_d = WAIT;
      WAIT:    if (settle_q == '0) state_d = CAPTURE;
      CAPTURE: state_d = EMIT;
      EMIT: begin
        if (handshake && region_last) state_d = addr_last ? DONE : SET;
      end
      DONE:    state_d = cont_i ? SET : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded control outputs
  always_comb begin
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE:    busy_o      = 1'b0;
      CAPTURE: capture     = 1'b1;
      EMIT:    out_valid_o = 1'b1;
      DONE:    done_o      = 1'b1;
      default: ;
    endcase
  end

  // Counters and the registered output word; the address only moves on entry to SET
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q   <= '0;
      region_q <= '0;
      settle_q <= '0;
      word_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) addr_q <= '0;
        end
        SET: begin
          settle_q <= SETTLE_LOAD;
        end
        WAIT: begin
          if (settle_q != '0) settle_q <= settle_q - SETTLE_W'(1);
        end
        CAPTURE: begin
          // Snapshot is not written yet, so region 0 is taken straight from the bus
          region_q <= '0;
          word_q   <= pack_word('0, FIELD_W'(addr_q), DATA_FIELD_W'(data_i[DATA_W-1:0]));
        end
        EMIT: begin
          if (handshake) begin
            if (!region_last) begin
              region_q <= rd_idx;
              word_q   <= pack_word(rd_idx, FIELD_W'(addr_q), DATA_FIELD_W'(rd_data));
            end else if (!addr_last) begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          if (cont_i) addr_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_readout_scanner.sv
// Directed testbench for ro_readout_scanner with a two-address sweep.
// The region model only reflects a new address three cycles after addr_o
// changes, so any capture taken before the settle time shows stale data.
module tb_ro_readout_scanner;

  localparam int NUM_REGION = 17;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 24;
  localparam int NUM_ADDR   = 2;
  localparam int SETTLE     = 4;
  localparam int TOTAL      = NUM_REGION * NUM_ADDR;
  localparam int LIMIT      = 400;

  logic                         clk = 1'b0;
  logic                         rstn;
  logic                         start_i;
  logic                         cont_i;
  logic [ADDR_W-1:0]            addr_o;
  logic [NUM_REGION*DATA_W-1:0] data_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [33:0]                  out_data_o;
  logic                         busy_o;
  logic                         done_o;

  int vectors     = 0;
  int miscompares = 0;

  int sw_words;
  int sw_dones;
  int sw_first_valid;
  int sw_done_cyc;

  logic [ADDR_W-1:0] a_d1, a_d2, a_d3;
  logic [33:0]       held;
  logic              found;

  ro_readout_scanner #(
    .NUM_REGION (NUM_REGION),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_ADDR   (NUM_ADDR),
    .SETTLE     (SETTLE)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .cont_i      (cont_i),
    .addr_o      (addr_o),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  // Region model: data follows the address with a three-cycle lag
  always @(posedge clk) begin
    a_d1 <= addr_o;
    a_d2 <= a_d1;
    a_d3 <= a_d2;
  end

  // Region r answers address a with a*256 + r
  always_comb begin
    data_i = '0;
    for (int r = 0; r < NUM_REGION; r++) begin
      data_i[r*DATA_W +: DATA_W] = {8'h00, 8'(a_d3), 8'(r)};
    end
  end

  function automatic logic [33:0] exp_word(input int idx);
    int a;
    int r;
    a = idx / NUM_REGION;
    r = idx % NUM_REGION;
    return {5'(r), 5'(a), 8'h00, 8'(a), 8'(r)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start from IDLE; returns in the SET cycle (cycle 1)
  task automatic apply_stimulus();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_output("set_addr", 64'(addr_o), 64'd0);
    check_output("set_busy", 64'(busy_o), 64'd1);
  endtask

  // Collect one sweep starting in its SET cycle; stops in the DONE cycle.
  // mode 0: ready held high, mode 1: ready pattern 1,0,0,1.
  task automatic run_sweep(input int mode, input bit poke_start);
    int   cyc;
    int   phase;
    bit   hold_pending;
    bit   poked;
    bit   seen_done;
    logic [33:0] hold_word;
    cyc            = 1;
    phase          = 0;
    hold_pending   = 0;
    poked          = 0;
    seen_done      = 0;
    hold_word      = '0;
    sw_words       = 0;
    sw_dones       = 0;
    sw_first_valid = -1;
    sw_done_cyc    = -1;
    for (int k = 0; k < LIMIT; k++) begin
      if (mode == 0) out_ready_i = 1'b1;
      else           out_ready_i = (phase % 4 == 0) || (phase % 4 == 3);
      phase++;
      if (poke_start && !poked && sw_words == 5) begin
        start_i = 1'b1;
        poked   = 1;
      end else begin
        start_i = 1'b0;
      end
      if (hold_pending) begin
        check_output("hold_valid", 64'(out_valid_o), 64'd1);
        check_output("hold_data", 64'(out_data_o), 64'(hold_word));
        hold_pending = 0;
      end
      if (out_valid_o) begin
        if (sw_first_valid < 0) sw_first_valid = cyc;
        if (out_ready_i) begin
          check_output("word_in_range", 64'(sw_words < TOTAL), 64'd1);
          check_output("word", 64'(out_data_o), 64'(exp_word(sw_words)));
          check_output("addr_stable", 64'(addr_o), 64'(sw_words / NUM_REGION));
          sw_words++;
        end else begin
          hold_pending = 1;
          hold_word    = out_data_o;
        end
      end
      if (done_o) begin
        sw_dones++;
        sw_done_cyc = cyc;
        seen_done   = 1;
      end
      if (seen_done) break;
      tick();
      cyc++;
    end
    start_i = 1'b0;
    check_output("sweep_done_seen", 64'(seen_done), 64'd1);
  endtask

  initial begin
    rstn        = 1'b0;
    start_i     = 1'b0;
    cont_i      = 1'b0;
    out_ready_i = 1'b0;
    repeat (3) tick();
    check_output("rst_valid", 64'(out_valid_o), 64'd0);
    check_output("rst_addr", 64'(addr_o), 64'd0);
    check_output("rst_data", 64'(out_data_o), 64'd0);
    check_output("rst_busy", 64'(busy_o), 64'd0);
    check_output("rst_done", 64'(done_o), 64'd0);
    rstn = 1'b1;
    tick();

    $display("[TB] basic sweep");
    apply_stimulus();
    run_sweep(0, 0);
    check_output("basic_first_valid", 64'(sw_first_valid), 64'd7);
    check_output("basic_words", 64'(sw_words), 64'(TOTAL));
    check_output("basic_done_cyc", 64'(sw_done_cyc), 64'd47);
    tick();
    check_output("basic_done_pulse", 64'(done_o), 64'd0);
    check_output("basic_idle", 64'(busy_o), 64'd0);

    $display("[TB] backpressure with start while busy");
    apply_stimulus();
    run_sweep(1, 1);
    check_output("bp_words", 64'(sw_words), 64'(TOTAL));
    check_output("bp_dones", 64'(sw_dones), 64'd1);
    tick();
    check_output("bp_idle", 64'(busy_o), 64'd0);
    repeat (5) tick();
    check_output("bp_no_restart", 64'(out_valid_o | busy_o | done_o), 64'd0);

    $display("[TB] continuous mode");
    out_ready_i = 1'b1;
    cont_i      = 1'b1;
    apply_stimulus();
    run_sweep(0, 0);
    check_output("cont1_words", 64'(sw_words), 64'(TOTAL));
    check_output("cont1_done_cyc", 64'(sw_done_cyc), 64'd47);
    tick();
    check_output("cont_busy", 64'(busy_o), 64'd1);
    check_output("cont_addr", 64'(addr_o), 64'd0);
    check_output("cont_done_pulse", 64'(done_o), 64'd0);
    cont_i = 1'b0;
    run_sweep(0, 0);
    check_output("cont2_first_valid", 64'(sw_first_valid), 64'd7);
    check_output("cont2_words", 64'(sw_words), 64'(TOTAL));
    tick();
    check_output("cont2_idle", 64'(busy_o), 64'd0);

    $display("[TB] reset mid-emit");
    out_ready_i = 1'b1;
    apply_stimulus();
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (out_valid_o && addr_o == 5'd1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_output("rst_reach_addr1", 64'(found), 64'd1);
    out_ready_i = 1'b0;
    held = out_data_o;
    check_output("rst_pre_word", 64'(held), 64'(exp_word(NUM_REGION)));
    tick();
    check_output("rst_pre_valid", 64'(out_valid_o), 64'd1);
    check_output("rst_pre_hold", 64'(out_data_o), 64'(held));
    rstn = 1'b0;
    tick();
    check_output("midrst_valid", 64'(out_valid_o), 64'd0);
    check_output("midrst_addr", 64'(addr_o), 64'd0);
    check_output("midrst_busy", 64'(busy_o), 64'd0);
    check_output("midrst_data", 64'(out_data_o), 64'd0);
    rstn        = 1'b1;
    out_ready_i = 1'b1;
    tick();
    apply_stimulus();
    run_sweep(0, 0);
    check_output("after_rst_first_valid", 64'(sw_first_valid), 64'd7);
    check_output("after_rst_words", 64'(sw_words), 64'(TOTAL));
    check_output("after_rst_done_cyc", 64'(sw_done_cyc), 64'd47);
    tick();
    check_output("after_rst_idle", 64'(busy_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
